// File: rtl/timer_arbiter.sv
// timer_arbiter: one down-counting timeout counter shared round-robin between
// NUM_REQ requesters. The winner's load value is captured at grant, counted
// down on enabled ticks, and a one-cycle done pulse is returned to it.
// Optional build macro TIMER_ARB_CANCEL_EN: when defined, the granted
// requester dropping its request while counting abandons the timeout.
`timescale 1ns/1ps

module timer_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clkIn,
  input  logic                     rstIn,
  input  logic [NUM_REQ-1:0]       reqIn,
  input  logic [NUM_REQ*CNT_W-1:0] loadValIn,
  input  logic                     tickEnIn,
  output logic [NUM_REQ-1:0]       grantOut,
  output logic                     busyOut,
  output logic [NUM_REQ-1:0]       doneOut,
  output logic [CNT_W-1:0]         cntValOut
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } stateT;

  stateT              state;
  logic [PTR_W-1:0]   rrPtr;
  logic [PTR_W-1:0]   ownerIdx;
  logic [PTR_W-1:0]   winIdx;
  logic               winFound;
  logic [NUM_REQ-1:0] winOneHot;
  logic [CNT_W-1:0]   winLoad;
  logic [CNT_W-1:0]   cnt;
  logic               cancelHit;
  int                 candIdx;

  // Round-robin search: start just after the last owner and wrap, so the
  // previous owner is considered last and nobody can be starved.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    candIdx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      candIdx = int'(rrPtr) + k;
      if (candIdx >= NUM_REQ) begin
        candIdx = candIdx - NUM_REQ;
      end
      if (!winFound && reqIn[PTR_W'(candIdx)]) begin
        winFound = 1'b1;
        winIdx   = PTR_W'(candIdx);
      end
    end
  end

  assign winOneHot = NUM_REQ'(1) << winIdx;
  assign winLoad   = loadValIn[int'(winIdx)*CNT_W +: CNT_W];
  assign cntValOut = cnt;

`ifdef TIMER_ARB_CANCEL_EN
  assign cancelHit = (state == COUNT) && !reqIn[ownerIdx];
`else
  assign cancelHit = 1'b0;
`endif

  // Main controller: grant and load from IDLE, count enabled ticks in COUNT,
  // pulse done for exactly one cycle in DONE, then hand the pointer on.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state    <= IDLE;
      grantOut <= '0;
      doneOut  <= '0;
      busyOut  <= 1'b0;
      cnt      <= '0;
      rrPtr    <= LAST_IDX;
      ownerIdx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winFound) begin
            grantOut <= winOneHot;
            cnt      <= winLoad;
            ownerIdx <= winIdx;
            busyOut  <= 1'b1;
            state    <= COUNT;
          end
        end
        COUNT: begin
          if (cancelHit) begin
            grantOut <= '0;
            busyOut  <= 1'b0;
            cnt      <= '0;
            rrPtr    <= ownerIdx;
            state    <= IDLE;
          end else if (tickEnIn) begin
            if (cnt == '0) begin
              doneOut <= grantOut;
              state   <= DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        DONE: begin
          grantOut <= '0;
          doneOut  <= '0;
          busyOut  <= 1'b0;
          rrPtr    <= ownerIdx;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed checks of the shared timeout arbiter. A table of
// single-cycle vectors covers basic loading, counting and tick gating; short
// hand-written sequences cover round-robin order, async reset and cancel.
`timescale 1ns/1ps

module tb_timer_arbiter;

  logic        clkIn;
  logic        rstIn;
  logic [3:0]  reqIn;
  logic [31:0] loadValIn;
  logic        tickEnIn;
  logic [3:0]  grantOut;
  logic        busyOut;
  logic [3:0]  doneOut;
  logic [7:0]  cntValOut;

  int errCount;
  int checkCount;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] load;
    logic        tick;
    logic [3:0]  expGrant;
    logic [3:0]  expDone;
    logic        expBusy;
    logic [7:0]  expCnt;
  } vecT;

  vecT vecs [20];

  timer_arbiter #(
    .NUM_REQ(4),
    .CNT_W  (8)
  ) dut (
    .clkIn    (clkIn),
    .rstIn    (rstIn),
    .reqIn    (reqIn),
    .loadValIn(loadValIn),
    .tickEnIn (tickEnIn),
    .grantOut (grantOut),
    .busyOut  (busyOut),
    .doneOut  (doneOut),
    .cntValOut(cntValOut)
  );

  // Free-running 100 MHz clock
  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  // Drive inputs, let one rising edge pass, then settle before sampling
  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] load, input logic tick);
    reqIn     = req;
    loadValIn = load;
    tickEnIn  = tick;
    @(posedge clkIn);
    #1;
  endtask

  // Compare the full output set against expectations
  task automatic checkOutput(input string name, input logic [3:0] expGrant, input logic [3:0] expDone,
                             input logic expBusy, input logic [7:0] expCnt);
    checkCount++;
    if ({grantOut, doneOut, busyOut, cntValOut} !== {expGrant, expDone, expBusy, expCnt}) begin
      errCount++;
      $display("[TB] FAIL %s: got grant=%b done=%b busy=%b cnt=%0d, expected grant=%b done=%b busy=%b cnt=%0d",
               name, grantOut, doneOut, busyOut, cntValOut, expGrant, expDone, expBusy, expCnt);
    end
  endtask

  // Compare one 4-bit value
  task automatic checkValue(input string name, input logic [3:0] act, input logic [3:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Record an expired wait as a failed comparison
  task automatic timeoutFail(input string name);
    checkCount++;
    errCount++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Hold reset for a cycle, check the reset state, then release
  task automatic doReset();
    rstIn     = 1'b1;
    reqIn     = '0;
    loadValIn = '0;
    tickEnIn  = 1'b0;
    @(posedge clkIn);
    #1;
    checkOutput("reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
    rstIn = 1'b0;
  endtask

  // Step until a fresh grant appears (not the DONE cycle) and check its owner
  task automatic waitGrant(input string name, input logic [3:0] expGrant);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      applyStimulus(reqIn, loadValIn, tickEnIn);
      n++;
      if (grantOut != 4'b0000 && doneOut == 4'b0000) seen = 1'b1;
    end
    if (seen) checkValue(name, grantOut, expGrant);
    else timeoutFail(name);
  endtask

  // Step until a done pulse appears and check it goes to the expected owner
  task automatic waitDone(input string name, input logic [3:0] expDone);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      applyStimulus(reqIn, loadValIn, tickEnIn);
      n++;
      if (doneOut != 4'b0000) seen = 1'b1;
    end
    if (seen) begin
      checkValue(name, doneOut, expDone);
      checkValue({name, "Grant"}, grantOut, expDone);
    end else begin
      timeoutFail(name);
    end
  endtask

  // Test sequence
  initial begin
    logic [3:0] pending;
    logic [3:0] expBit;

    errCount   = 0;
    checkCount = 0;

    // Rows 0-6: requester 0, load 3, ticking every cycle
    vecs[0]  = '{4'b0001, 32'h0000_0003, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'd3};
    vecs[1]  = '{4'b0001, 32'h0000_0003, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'd2};
    vecs[2]  = '{4'b0001, 32'h0000_0003, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'd1};
    vecs[3]  = '{4'b0001, 32'h0000_0003, 1'b1, 4'b0001, 4'b0000, 1'b1, 8'd0};
    vecs[4]  = '{4'b0001, 32'h0000_0003, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'd0};
    vecs[5]  = '{4'b0000, 32'h0000_0003, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0};
    vecs[6]  = '{4'b0000, 32'h0000_0003, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0};
    // Rows 7-19: requester 1, load 5, tick toggling; load changes after grant
    // and other requesters toggle, neither may disturb the active count
    vecs[7]  = '{4'b0010, 32'h0000_0500, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd5};
    vecs[8]  = '{4'b0010, 32'h0000_0900, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'd4};
    vecs[9]  = '{4'b0111, 32'h0000_0900, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd4};
    vecs[10] = '{4'b0010, 32'h0000_0900, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'd3};
    vecs[11] = '{4'b1010, 32'h0000_0900, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd3};
    vecs[12] = '{4'b0010, 32'h0000_0900, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'd2};
    vecs[13] = '{4'b0010, 32'h0000_0900, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd2};
    vecs[14] = '{4'b0010, 32'h0000_0900, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'd1};
    vecs[15] = '{4'b0010, 32'h0000_0900, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd1};
    vecs[16] = '{4'b0010, 32'h0000_0900, 1'b1, 4'b0010, 4'b0000, 1'b1, 8'd0};
    vecs[17] = '{4'b0010, 32'h0000_0900, 1'b0, 4'b0010, 4'b0000, 1'b1, 8'd0};
    vecs[18] = '{4'b0010, 32'h0000_0900, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'd0};
    vecs[19] = '{4'b0000, 32'h0000_0900, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'd0};

    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].req, vecs[i].load, vecs[i].tick);
      checkOutput($sformatf("vec%0d", i), vecs[i].expGrant, vecs[i].expDone,
                  vecs[i].expBusy, vecs[i].expCnt);
    end

    // All four requesting with zero loads: strict round-robin order
    doReset();
    reqIn     = 4'b1111;
    loadValIn = 32'h0000_0000;
    tickEnIn  = 1'b1;
    pending   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      expBit = 4'b0001 << i;
      waitGrant($sformatf("rrGrant%0d", i), expBit);
      waitDone($sformatf("rrDone%0d", i), expBit);
      pending = pending & ~expBit;
      applyStimulus(pending, 32'h0000_0000, 1'b1);
      checkValue($sformatf("rrPulse%0d", i), doneOut, 4'b0000);
    end

    // Two requesters held continuously: they must alternate
    doReset();
    reqIn     = 4'b0101;
    loadValIn = 32'h0101_0101;
    tickEnIn  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expBit = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      waitGrant($sformatf("altGrant%0d", i), expBit);
      waitDone($sformatf("altDone%0d", i), expBit);
    end

    // Asynchronous reset in the middle of a count
    doReset();
    applyStimulus(4'b0001, 32'h0000_0004, 1'b1);
    applyStimulus(4'b0001, 32'h0000_0004, 1'b1);
    applyStimulus(4'b0001, 32'h0000_0004, 1'b1);
    checkOutput("preReset", 4'b0001, 4'b0000, 1'b1, 8'd2);
    rstIn = 1'b1;
    #2;
    checkOutput("asyncReset", 4'b0000, 4'b0000, 1'b0, 8'd0);
    reqIn = 4'b0000;
    @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b0000, 32'h0000_0004, 1'b1);
      checkOutput($sformatf("postReset%0d", i), 4'b0000, 4'b0000, 1'b0, 8'd0);
    end
    applyStimulus(4'b1111, 32'h0000_0000, 1'b1);
    checkOutput("postResetGrant", 4'b0001, 4'b0000, 1'b1, 8'd0);

    // Granted requester drops its request at count 3
    doReset();
    applyStimulus(4'b0001, 32'h0000_0005, 1'b1);
    applyStimulus(4'b0001, 32'h0000_0005, 1'b1);
    applyStimulus(4'b0001, 32'h0000_0005, 1'b1);
    checkOutput("cancelPre", 4'b0001, 4'b0000, 1'b1, 8'd3);
`ifdef TIMER_ARB_CANCEL_EN
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("cancelIdle", 4'b0000, 4'b0000, 1'b0, 8'd0);
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("cancelNoDone", 4'b0000, 4'b0000, 1'b0, 8'd0);
`else
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("dropCnt2", 4'b0001, 4'b0000, 1'b1, 8'd2);
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("dropCnt1", 4'b0001, 4'b0000, 1'b1, 8'd1);
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("dropCnt0", 4'b0001, 4'b0000, 1'b1, 8'd0);
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("dropDone", 4'b0001, 4'b0001, 1'b1, 8'd0);
    applyStimulus(4'b0000, 32'h0000_0005, 1'b1);
    checkOutput("dropIdle", 4'b0000, 4'b0000, 1'b0, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
Name: timer_arbiter

Overview:
- Shares one down-counting timeout counter between NUM_REQ requesters.
- Each requester asks for a timeout of its own length. A round-robin arbiter grants the counter to one requester at a time.
- The block loads the winner's value, counts enabled ticks, then pulses that requester's done line.
- Sits between protocol FSMs that need watchdog/delay timing and a single shared counter datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- CNT_W, 8, counter width in bits; also the width of each load value.

Ports:
- clkIn  input  1  system clock, rising edge.
- rstIn  input  1  asynchronous, active-high reset.
- reqIn  input  NUM_REQ  level request per requester; held high until done (or cancel).
- loadValIn  input  NUM_REQ*CNT_W  requester i's timeout in bits [i*CNT_W +: CNT_W]; sampled only at grant.
- tickEnIn  input  1  count enable; the counter advances only on cycles where this is 1.
- grantOut  output  NUM_REQ  one-hot registered grant; all-zero when idle.
- busyOut  output  1  high while in COUNT or DONE.
- doneOut  output  NUM_REQ  one-cycle done pulse to the granted requester.
- cntValOut  output  CNT_W  current counter value.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clkIn, rstIn).
- Reset values: state=IDLE, grantOut=0, doneOut=0, busyOut=0, cntValOut=0, rrPtr=NUM_REQ-1 (so index 0 wins first). Reset mid-count abandons the timeout with no done pulse.
- States: IDLE, COUNT, DONE.
- IDLE:
  - If any reqIn bit is high, pick the winner by searching from rrPtr+1 upward, wrapping modulo NUM_REQ.
  - Next edge: grantOut=onehot(winner), cnt=loadValIn[winner], state=COUNT.
  - If reqIn is all zero, stay in IDLE.
- COUNT, on each edge with tickEnIn=1:
  - cnt==0 -> state=DONE.
  - Otherwise cnt=cnt-1.
  - tickEnIn=0 holds cnt and state.
  - A load value L completes after exactly L+1 enabled ticks; L=0 completes on the first enabled tick.
  - No wrap: the count never goes below 0.
- DONE (exactly one cycle):
  - doneOut=grantOut.
  - Next edge: grantOut=0, doneOut=0, rrPtr=winner index, state=IDLE.
- Request rules:
  - A requester drops reqIn in the cycle after seeing doneOut.
  - If reqIn is still high in IDLE, it is a new request, but other pending requesters win first.
  - reqIn changes of non-granted requesters never disturb the active timeout.
- Latency: request visible in IDLE at edge t -> grant and load at edge t+1 -> done pulse visible (L+1) enabled ticks later plus 1 cycle; minimum 3 edges from request to done pulse.
- Back-to-back: IDLE lasts at least one cycle between grants; there is no grant-to-grant bypass.
- Simultaneous requests: round-robin only; no index holds static priority except at reset.
- cntValOut mirrors cnt. It keeps its last value (0) in IDLE until the next load.

Optional Feature:
- Macro: TIMER_ARB_CANCEL_EN.
- Defined: if the granted requester's reqIn drops in COUNT, the next edge goes to IDLE with grantOut=0, no done pulse, rrPtr=winner, cnt=0.
- Not defined: a drop of the granted reqIn is ignored; the count runs to completion and doneOut still pulses.

Test Plan:
- Reset, then reqIn=0001, load0=3, tickEnIn=1 -> grantOut=0001 one cycle later; cntValOut 3,2,1,0; doneOut=0001 for one cycle after 4 ticks; grantOut=0 the following cycle.
- reqIn=1111, all loads=0, requesters dropping req after their done -> grants in order 0001,0010,0100,1000; each doneOut pulse is one cycle.
- reqIn=0101 held continuously, loads=1 -> grants alternate 0001,0100,0001; no starvation of index 2.
- load=5, tickEnIn toggling 1,0,1,0... -> cntValOut holds on 0 cycles; done after 6 enabled ticks (about 12 cycles).
- rstIn pulse while cntValOut=2 in COUNT -> all outputs 0 immediately (async); no doneOut pulse; next grant goes to index 0.
- Granted reqIn dropped at cntValOut=3 -> with TIMER_ARB_CANCEL_EN: return to IDLE next edge with no done pulse; without it: count to 0 and doneOut pulses.
